// File: rtl/smoldvi_pkg.sv
// Shared definitions for the smoldvi TMDS receive path:
//   W_OUT_DEFAULT        - default TMDS symbol width
//   TMDS_CTRL_00..11     - the four TMDS control-period token encodings
//   rx_state_e           - receive alignment FSM states
package smoldvi_pkg;

  localparam int unsigned W_OUT_DEFAULT = 10;

  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic [1:0] {
    RX_SEARCH = 2'd0,
    RX_CHECK  = 2'd1,
    RX_LOCKED = 2'd2
  } rx_state_e;

endpackage

// File: rtl/smoldvi_tmds_ctrl_detect.sv
// Combinational TMDS control-token matcher.
//   sym     in  W_OUT  symbol, sym[0] first on the line
//   is_ctrl out 1      high when sym is one of the four control tokens
module smoldvi_tmds_ctrl_detect
  import smoldvi_pkg::*;
#(
  parameter int unsigned W_OUT = W_OUT_DEFAULT
) (
  input  logic [W_OUT-1:0] sym,
  output logic             is_ctrl
);

  always_comb begin
    is_ctrl = (sym == W_OUT'(TMDS_CTRL_00)) ||
              (sym == W_OUT'(TMDS_CTRL_01)) ||
              (sym == W_OUT'(TMDS_CTRL_10)) ||
              (sym == W_OUT'(TMDS_CTRL_11));
  end

endmodule

// File: rtl/smoldvi_rx_gearbox.sv
// Receive gearbox: assembles W_IN-bit captures into W_OUT-bit TMDS symbols
// and bit-slips the symbol window until control tokens line up.
//   clk           in   single clock
//   rst           in   asynchronous, active-high reset
//   din           in   W_IN line bits, din[0] earliest
//   dout          out  W_OUT aligned symbol, dout[0] first on the line
//   dout_valid    out  one-cycle strobe every W_OUT/W_IN clocks
//   locked        out  alignment lock held
//   align_offset  out  window offset in bits, 0..W_OUT-1
//   lock_loss_cnt out  saturating lock-loss count when SMOLDVI_RX_STATS_EN
//                      is defined, otherwise tied to 0
module smoldvi_rx_gearbox
  import smoldvi_pkg::*;
#(
  parameter int unsigned W_IN     = 2,
  parameter int unsigned W_OUT    = W_OUT_DEFAULT,
  parameter int unsigned LOCK_RUN = 8,
  parameter int unsigned MAX_GAP  = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W_IN-1:0]          din,
  output logic [W_OUT-1:0]         dout,
  output logic                     dout_valid,
  output logic                     locked,
  output logic [$clog2(W_OUT)-1:0] align_offset,
  output logic [15:0]              lock_loss_cnt
);

  localparam int unsigned N     = W_OUT / W_IN;
  localparam int unsigned PH_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OFF_W = $clog2(W_OUT);
  localparam int unsigned IDX_W = $clog2(2 * W_OUT);
  localparam int unsigned RUN_W = $clog2(LOCK_RUN + 1);
  localparam int unsigned GAP_W = $clog2(MAX_GAP + 1);

  logic [2*W_OUT-1:0] hist_q, hist_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic               word_rdy_q, word_rdy_d;
  logic [W_OUT-1:0]   dout_q, dout_d;
  logic               valid_q, valid_d;
  rx_state_e          state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [OFF_W-1:0]   off_q, off_d;

  logic [IDX_W-1:0]   cand_base;
  logic [W_OUT-1:0]   cand;
  logic               is_ctrl;
  logic [OFF_W-1:0]   off_inc;
  logic [RUN_W-1:0]   run_inc;
  logic [GAP_W-1:0]   gap_inc;

  // Datapath: shift register, phase counter and candidate window.
  // word_rdy_q marks the cycle after phase wrapped, so the post-reset
  // phase of 0 never yields a spurious word.
  always_comb begin
    hist_d     = {din, hist_q[2*W_OUT-1:W_IN]};
    word_rdy_d = (phase_q == PH_W'(N - 1));
    phase_d    = word_rdy_d ? '0 : phase_q + PH_W'(1);
    cand_base  = IDX_W'(W_OUT) - IDX_W'(off_q);
    cand       = hist_q[cand_base +: W_OUT];
    dout_d     = word_rdy_q ? cand : dout_q;
    valid_d    = word_rdy_q;
  end

  smoldvi_tmds_ctrl_detect #(
    .W_OUT(W_OUT)
  ) u_ctrl_detect (
    .sym    (cand),
    .is_ctrl(is_ctrl)
  );

  // Alignment FSM, stepped once per candidate word.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    gap_d   = gap_q;
    off_d   = off_q;
    off_inc = (off_q == OFF_W'(W_OUT - 1)) ? '0 : off_q + OFF_W'(1);
    run_inc = run_q + RUN_W'(1);
    gap_inc = (gap_q == GAP_W'(MAX_GAP)) ? gap_q : gap_q + GAP_W'(1);
    if (word_rdy_q) begin
      case (state_q)
        RX_SEARCH: begin
          if (is_ctrl) begin
            state_d = RX_CHECK;
            run_d   = RUN_W'(1);
          end else begin
            off_d = off_inc;
          end
        end
        RX_CHECK: begin
          if (is_ctrl) begin
            run_d = run_inc;
            if (run_inc == RUN_W'(LOCK_RUN)) begin
              state_d = RX_LOCKED;
              gap_d   = '0;
            end
          end else begin
            state_d = RX_SEARCH;
            run_d   = '0;
            off_d   = off_inc;
          end
        end
        RX_LOCKED: begin
          if (is_ctrl) begin
            gap_d = '0;
          end else begin
            gap_d = gap_inc;
            // Lock loss keeps the current offset; no slip here.
            if (gap_inc == GAP_W'(MAX_GAP)) begin
              state_d = RX_SEARCH;
              run_d   = '0;
            end
          end
        end
        default: state_d = RX_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q     <= '0;
      phase_q    <= '0;
      word_rdy_q <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      state_q    <= RX_SEARCH;
      run_q      <= '0;
      gap_q      <= '0;
      off_q      <= '0;
    end else begin
      hist_q     <= hist_d;
      phase_q    <= phase_d;
      word_rdy_q <= word_rdy_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      state_q    <= state_d;
      run_q      <= run_d;
      gap_q      <= gap_d;
      off_q      <= off_d;
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = valid_q;
  assign locked       = (state_q == RX_LOCKED);
  assign align_offset = off_q;

`ifdef SMOLDVI_RX_STATS_EN
  logic        lost;
  logic [15:0] loss_q, loss_d;

  assign lost = (state_q == RX_LOCKED) && (state_d == RX_SEARCH);

  always_comb begin
    loss_d = loss_q;
    if (lost && (loss_q != '1)) begin
      loss_d = loss_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_smoldvi_rx_gearbox.sv
module tb_smoldvi_rx_gearbox;

  localparam int unsigned W_IN     = 2;
  localparam int unsigned W_OUT    = 10;
  localparam int unsigned LOCK_RUN = 8;
  localparam int unsigned MAX_GAP  = 4096;

`ifdef SMOLDVI_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  din;
  logic [9:0]  dout;
  logic        dout_valid;
  logic        locked;
  logic [3:0]  align_offset;
  logic [15:0] lock_loss_cnt;

  always #5 clk = ~clk;

  smoldvi_rx_gearbox #(
    .W_IN    (W_IN),
    .W_OUT   (W_OUT),
    .LOCK_RUN(LOCK_RUN),
    .MAX_GAP (MAX_GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .locked       (locked),
    .align_offset (align_offset),
    .lock_loss_cnt(lock_loss_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the whole line since reset as a bit list; word w ends at bit 10w,
  // the window at offset k covers bits 10w-10-k .. 10w-1-k.
  bit          line[$];
  int          samples;
  bit          pend;
  int          pend_end;
  int          m_mode;   // 0 search, 1 check, 2 locked
  int          m_run;
  int          m_gap;
  int          m_off;
  int          m_loss;
  logic [9:0]  exp_dout;
  logic        exp_valid;
  logic        exp_locked;
  logic [3:0]  exp_off;
  logic [15:0] exp_loss;
  bit          chk_en = 1'b0;

  function automatic bit is_tok(input logic [9:0] v);
    return (v == 10'h354) || (v == 10'h0AB) || (v == 10'h154) || (v == 10'h2AB);
  endfunction

  task automatic model_reset();
    line.delete();
    samples = 0; pend = 0; pend_end = 0;
    m_mode = 0; m_run = 0; m_gap = 0; m_off = 0; m_loss = 0;
    exp_dout = '0; exp_valid = 1'b0; exp_locked = 1'b0; exp_off = '0; exp_loss = '0;
  endtask

  task automatic model_step(input logic [1:0] d);
    logic [9:0] c;
    int idx;
    line.push_back(d[0]);
    line.push_back(d[1]);
    samples++;
    exp_valid = 1'b0;
    if (pend) begin
      for (int i = 0; i < 10; i++) begin
        idx = pend_end - 10 - m_off + i;
        c[i] = (idx >= 0) ? line[idx] : 1'b0;
      end
      exp_dout = c;
      exp_valid = 1'b1;
      pend = 0;
      if (is_tok(c)) begin
        if (m_mode == 0) begin
          m_mode = 1; m_run = 1;
        end else if (m_mode == 1) begin
          m_run++;
          if (m_run == LOCK_RUN) begin m_mode = 2; m_gap = 0; end
        end else begin
          m_gap = 0;
        end
      end else begin
        if (m_mode == 0) begin
          m_off = (m_off + 1) % W_OUT;
        end else if (m_mode == 1) begin
          m_mode = 0; m_off = (m_off + 1) % W_OUT;
        end else begin
          if (m_gap < MAX_GAP) m_gap++;
          if (m_gap == MAX_GAP) begin
            m_mode = 0; m_run = 0;
            if (m_loss < 65535) m_loss++;
          end
        end
      end
    end
    if (samples % 5 == 0) begin
      pend = 1;
      pend_end = samples * 2;
    end
    exp_locked = (m_mode == 2);
    exp_off = 4'(m_off);
    exp_loss = STATS ? 16'(m_loss) : 16'd0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("dout_valid", {31'd0, dout_valid}, {31'd0, exp_valid});
      check("dout", {22'd0, dout}, {22'd0, exp_dout});
      check("locked", {31'd0, locked}, {31'd0, exp_locked});
      check("align_offset", {28'd0, align_offset}, {28'd0, exp_off});
      check("lock_loss_cnt", {16'd0, lock_loss_cnt}, {16'd0, exp_loss});
    end
  end

  // Observation counters for the hand-computed checks.
  int  vcnt, dcnt, rise_vcnt, fall_dcnt, fall_off;
  bit  prev_locked, rise_with_valid;
  bit  txq[$];

  task automatic tick(input logic [1:0] d);
    din = d;
    @(posedge clk);
    #1;
    if (!rst) model_step(d);
    if (dout_valid) begin
      vcnt++;
      if (dout == 10'h1F0) dcnt++;
    end
    if (locked && !prev_locked) begin
      rise_vcnt = vcnt;
      rise_with_valid = dout_valid;
    end
    if (!locked && prev_locked) begin
      fall_dcnt = dcnt;
      fall_off = align_offset;
    end
    prev_locked = locked;
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) txq.push_back(s[i]);
  endtask

  task automatic tick_q();
    bit b0, b1;
    if (txq.size() < 2) push_sym(10'h354);
    b0 = txq.pop_front();
    b1 = txq.pop_front();
    tick({b1, b0});
  endtask

  task automatic send_sym(input logic [9:0] s);
    push_sym(s);
    while (txq.size() >= 2) tick_q();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    txq.delete();
    din = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vcnt = 0; dcnt = 0; rise_vcnt = -1; fall_dcnt = -1; fall_off = -1;
    prev_locked = 0; rise_with_valid = 0;
  endtask

  initial begin
    int cnt, last_v;
    rst = 1'b1;
    din = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", {22'd0, dout}, 32'd0);
    check("reset_valid", {31'd0, dout_valid}, 32'd0);
    check("reset_locked", {31'd0, locked}, 32'd0);
    check("reset_offset", {28'd0, align_offset}, 32'd0);
    check("reset_loss", {16'd0, lock_loss_cnt}, 32'd0);

    // Aligned token stream.
    do_reset();
    for (int i = 0; i < 40 && !locked; i++) send_sym(10'h354);
    check("aligned_locked", {31'd0, locked}, 32'd1);
    check("aligned_lock_valid_no", rise_vcnt, 32'd8);
    check("aligned_lock_with_valid", {31'd0, rise_with_valid}, 32'd1);
    check("aligned_offset", {28'd0, align_offset}, 32'd0);
    check("aligned_dout", {22'd0, dout}, 32'h354);

    // Lock loss after MAX_GAP data words.
    send_sym(10'h354);
    send_sym(10'h354);
    dcnt = 0;
    for (int i = 0; i < 4100; i++) send_sym(10'h1F0);
    check("gap_fall_word", fall_dcnt, 32'd4096);
    check("gap_fall_offset_kept", fall_off, 32'd0);
    check("gap_unlocked", {31'd0, locked}, 32'd0);
    check("gap_loss_cnt", {16'd0, lock_loss_cnt}, STATS ? 32'd1 : 32'd0);

    // Three-bit line delay.
    do_reset();
    for (int i = 0; i < 3; i++) txq.push_back(1'b0);
    for (int i = 0; i < 60 && !locked; i++) send_sym(10'h354);
    check("delay3_locked", {31'd0, locked}, 32'd1);
    check("delay3_offset", {28'd0, align_offset}, 32'd7);
    check("delay3_lock_valid_no", rise_vcnt, 32'd15);
    send_sym(10'h354);
    send_sym(10'h354);
    check("delay3_dout", {22'd0, dout}, 32'h354);

    // Data word while in CHECK after five tokens.
    do_reset();
    for (int i = 0; i < 5; i++) send_sym(10'h354);
    send_sym(10'h1F0);
    send_sym(10'h354);
    check("check_break_offset", {28'd0, align_offset}, 32'd1);
    check("check_break_unlocked", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 40 && !locked; i++) send_sym(10'h354);
    check("check_break_relock_valid_no", rise_vcnt, 32'd23);
    check("check_break_relock_offset", {28'd0, align_offset}, 32'd0);

    // Reset at phase 2 while locked.
    do_reset();
    for (int i = 0; i < 40 && !locked; i++) send_sym(10'h354);
    check("midrst_locked_before", {31'd0, locked}, 32'd1);
    cnt = 0;
    while (!dout_valid && cnt < 10) begin tick_q(); cnt++; end
    check("midrst_found_valid", {31'd0, dout_valid}, 32'd1);
    tick_q();
    rst = 1'b1;
    model_reset();
    txq.delete();
    #2;
    check("midrst_dout", {22'd0, dout}, 32'd0);
    check("midrst_valid", {31'd0, dout_valid}, 32'd0);
    check("midrst_locked", {31'd0, locked}, 32'd0);
    check("midrst_offset", {28'd0, align_offset}, 32'd0);
    check("midrst_loss", {16'd0, lock_loss_cnt}, 32'd0);
    tick(2'b00);
    rst = 1'b0;
    prev_locked = 0;
    cnt = 0;
    while (cnt < 20) begin
      tick_q();
      cnt++;
      if (dout_valid) break;
    end
    check("midrst_first_valid_clks", cnt, 32'd6);

    // Random line noise.
    do_reset();
    last_v = -1;
    for (int i = 0; i < 20000; i++) begin
      tick(2'($urandom_range(0, 3)));
      if (dout_valid) begin
        if (last_v >= 0) check("noise_valid_period", i - last_v, 32'd5);
        check("noise_offset_range", {31'd0, (align_offset <= 4'd9)}, 32'd1);
        last_v = i;
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
